// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle unsigned restoring divider
//
// Accepts a dividend/divisor pair through a start/ready handshake and runs
// one shift-subtract-restore step per clock for WIDTH clocks, then presents
// a registered quotient, remainder and divide-by-zero flag together with a
// one-cycle done pulse. A zero divisor skips the iterations entirely.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        division request, sampled only while ready=1
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   ready        high in IDLE (combinational decode of state)
//   busy         high while iterations are in progress
//   done         one-cycle pulse when results become valid
//   quotient     result, held until the next completion
//   remainder    result, held until the next completion
//   div_by_zero  set with the results when the divisor was zero

module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Partial remainder carries one extra bit so the trial subtraction's
    // sign can be read directly from its MSB.
    logic [WIDTH:0]   a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;

    logic [2*WIDTH:0] aq_shift;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic             divisor_zero;
    logic             last_iter;

    assign ready = (state == IDLE);

    // One iteration of the restoring algorithm, computed from the current
    // registers and committed on the next edge while in DIVIDE.
    always_comb begin
        aq_shift = {a, q} << 1;
        a_shift  = aq_shift[2*WIDTH:WIDTH];
        q_shift  = aq_shift[WIDTH-1:0];
        trial    = a_shift - {1'b0, m};
        if (trial[WIDTH]) begin
            // Negative trial: divisor did not fit, keep the shifted value.
            a_step = a_shift;
            q_step = {q_shift[WIDTH-1:1], 1'b0};
        end else begin
            a_step = trial;
            q_step = {q_shift[WIDTH-1:1], 1'b1};
        end
    end

    assign divisor_zero = (divisor == '0);
    assign last_iter    = (state == DIVIDE) && (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a           <= '0;
            q           <= '0;
            m           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (!divisor_zero) begin
                            a    <= '0;
                            q    <= dividend;
                            m    <= divisor;
                            cnt  <= CW'(WIDTH);
                            busy <= 1'b1;
                        end else begin
                            // Zero divisor completes immediately with a
                            // saturated quotient and the dividend passed
                            // through as remainder.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    a   <= a_step;
                    q   <= q_step;
                    cnt <= cnt - CW'(1);
                    if (last_iter) begin
                        quotient    <= q_step;
                        remainder   <= a_step[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Multi-cycle unsigned restoring divider. It is the inverse-operation companion to the team's Booth shift-add multiplier datapath. The block accepts a dividend and a divisor through a start/ready handshake and runs one shift-subtract-restore step per clock for WIDTH clocks. It then presents a registered quotient, remainder and divide-by-zero flag with a one-cycle done pulse. It sits in the arithmetic unit next to the multiplier and is driven by the same controller.

## Interface
- WIDTH, 4: operand, quotient and remainder width in bits. Legal range is 2..32.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin a division. Sampled only when ready=1.
- dividend  in  WIDTH  unsigned dividend. Sampled on the accepting edge.
- divisor  in  WIDTH  unsigned divisor. Sampled on the accepting edge.
- ready  out  1  high in IDLE only. Combinational decode of state.
- busy  out  1  registered; high while iterations are in progress.
- done  out  1  registered; one-cycle pulse when results become valid.
- quotient  out  WIDTH  registered result. Held until the next completion.
- remainder  out  WIDTH  registered result. Held until the next completion.
- div_by_zero  out  1  registered; set with the results when divisor was 0.

## Operation
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers 0. Reset asserted mid-division aborts at once and produces no done pulse.
- Internal registers:
  - A: partial remainder, WIDTH+1 bits (extra bit is the sign).
  - Q: dividend/quotient shift register, WIDTH bits.
  - M: latched divisor, WIDTH bits, zero-extended to WIDTH+1 for subtraction.
  - cnt: iteration counter, ceil(log2(WIDTH+1)) bits.
- FSM states: IDLE, DIVIDE, DONE.
- IDLE with start=1 and divisor≠0:
  - Load A=0, Q=dividend, M=divisor, cnt=WIDTH.
  - Set busy=1 and go to DIVIDE.
- IDLE with start=1 and divisor=0:
  - quotient = all ones, remainder = dividend, div_by_zero=1, done=1.
  - Go to DONE. busy stays 0.
- IDLE with start=0: no change.
- DIVIDE, per edge:
  - Shift {A,Q} left by 1.
  - Compute T = A_shifted − M at WIDTH+1 bits.
  - If T[WIDTH]=1 (negative): keep A_shifted and set Q[0]=0 (restore).
  - Otherwise: A=T and Q[0]=1.
  - Decrement cnt.
- DIVIDE, on the edge where cnt goes 1→0:
  - quotient = new Q, remainder = new A[WIDTH-1:0], div_by_zero=0.
  - done=1, busy=0, go to DONE.
- DONE: on the next edge, done=0 and go to IDLE.
- start is ignored in DIVIDE and DONE (ready=0). The operand inputs are don't-care outside the accepting edge.
- Invariant at completion: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Edge 0 is the edge that samples start=1 with ready=1.
- Nonzero divisor:
  - busy is high from edge 0 to edge WIDTH.
  - Iterations run on edges 1..WIDTH.
  - done is high for exactly one cycle, between edge WIDTH and edge WIDTH+1.
  - ready returns after edge WIDTH+1.
  - Back-to-back throughput is one division per WIDTH+2 cycles.
- Zero divisor:
  - done is high between edge 0 and edge 1.
  - ready returns after edge 1.
- quotient, remainder and div_by_zero change only on the edge that raises done, or on reset.
- start held high continuously: a new operation is accepted on every edge where ready=1, with no extra gap.

## Test plan
- WIDTH=4, 13÷3, start pulsed for one cycle -> quotient=4, remainder=1, div_by_zero=0. done exactly 4 edges after accept, one cycle wide. busy high for 4 cycles.
- WIDTH=4, 15÷1, then 5÷7, then 0÷5, all back-to-back with start held high -> results (15,0), (0,5), (0,0). Accepts spaced 6 cycles apart.
- WIDTH=4, 9÷0 -> quotient=15, remainder=9, div_by_zero=1, done one edge after accept, busy never high. A following 9÷2 -> (4,1) with div_by_zero=0.
- WIDTH=4, start 12÷5, then pulse start with 7÷1 on edge 2 -> second request ignored, result (2,2). Outputs unchanged until done.
- WIDTH=4, start 14÷3, assert rst after edge 2 -> all outputs return to reset values immediately with no done pulse. After release, 14÷3 -> (4,2).
- WIDTH=8, 200÷7 and 255÷255 -> (28,4) and (1,0), done 8 edges after accept. Plus 1000 random nonzero-divisor pairs checked against q·d+r=n and r<d.
